// File: rtl/mat_result_reader_pkg.sv
// Shared types and constants for the matrix result unloader.
// The sign-extension helper is used by mat_result_reader when MAT_RESULT_SIGN_EXT_EN is set.
package mat_result_pkg;

  localparam int ELEM_W   = 6;
  localparam int NUM_ELEM = 16;
  localparam int MAT_W    = ELEM_W * NUM_ELEM;
  localparam int IDX_W    = $clog2(NUM_ELEM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  // A subtraction result is a 3-bit two's-complement value in the low bits of its field.
  function automatic logic [ELEM_W-1:0] elem_fmt(input logic [ELEM_W-1:0] field,
                                                  input logic              sgn);
    return sgn ? {{(ELEM_W-3){field[2]}}, field[2:0]} : field;
  endfunction

endpackage

// File: rtl/mat_result_reader_if.sv
// Element stream from the result unloader to its downstream consumer.
interface mat_result_reader_if;
  import mat_result_pkg::*;

  logic [ELEM_W-1:0] elem_data;
  logic [IDX_W-1:0]  elem_idx;
  logic              elem_valid;
  logic              elem_ready;
  logic              elem_last;

  modport master (
    output elem_data, elem_idx, elem_valid, elem_last,
    input  elem_ready
  );

  modport slave (
    input  elem_data, elem_idx, elem_valid, elem_last,
    output elem_ready
  );
endinterface

// File: rtl/mat_result_reader_shifter.sv
// result_unload_shifter: capture register that loads a packed matrix and unloads it
// MSB-first one field at a time, zero-filling from the bottom.
module result_unload_shifter #(
  parameter int W     = 96,
  parameter int TAP_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             clr,
  input  logic [W-1:0]     d,
  output logic [TAP_W-1:0] tap
);

  logic [W-1:0] cap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cap <= '0;
    end else if (load) begin
      cap <= d;
    end else if (shift) begin
      cap <= {cap[W-TAP_W-1:0], {TAP_W{1'b0}}};
    end
  end

  assign tap = cap[W-1 -: TAP_W];

endmodule

// File: rtl/mat_result_reader.sv
// mat_result_reader: captures the packed result on a rising finish and streams it out
// one element per beat. Define MAT_RESULT_SIGN_EXT_EN to add the sign port and sign extension.
//
// state | meaning
// IDLE  | waiting for a rising edge on finish
// SEND  | presenting cap[top] as a valid beat, shifting on each accept
// DONE  | one-cycle done pulse, capture register cleared
module mat_result_reader
  import mat_result_pkg::*;
#(
  parameter int NUM_ELEM = 16,
  parameter int ELEM_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef MAT_RESULT_SIGN_EXT_EN
  input  logic                       sign,
`endif
  input  logic [NUM_ELEM*ELEM_W-1:0] mat_in,
  input  logic                       finish,
  mat_result_reader_if.master        elem,
  output logic                       busy,
  output logic                       done
);

  localparam int                  IW       = $clog2(NUM_ELEM);
  localparam logic [IW-1:0]       IDX_LAST = IW'(NUM_ELEM - 1);

  rd_state_t   state, state_nxt;
  logic        finish_q;
  logic        start;
  logic [IW-1:0] idx;
  logic        load, shift, clr;
  logic [ELEM_W-1:0] tap;
  logic        sign_q;
  logic        send;

  assign start = finish & ~finish_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      finish_q <= 1'b0;
      state    <= IDLE;
      idx      <= '0;
    end else begin
      finish_q <= finish;
      state    <= state_nxt;
      if (load) begin
        idx <= '0;
      end else if (shift) begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef MAT_RESULT_SIGN_EXT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
    end else if (load) begin
      sign_q <= sign;
    end
  end
`else
  assign sign_q = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (elem.elem_ready) begin
          shift = 1'b1;
          if (idx == IDX_LAST) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        clr       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  result_unload_shifter #(
    .W     (NUM_ELEM * ELEM_W),
    .TAP_W (ELEM_W)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .clr   (clr),
    .d     (mat_in),
    .tap   (tap)
  );

  // Everything below decodes registered state only; elem_ready never reaches elem_valid.
  assign send            = (state == SEND);
  assign elem.elem_valid = send;
  assign elem.elem_data  = send ? elem_fmt(tap, sign_q) : '0;
  assign elem.elem_idx   = send ? idx : '0;
  assign elem.elem_last  = send && (idx == IDX_LAST);
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_mat_result_reader.sv
// Directed and randomized checks of mat_result_reader against a slice-based element model.
module tb_mat_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] mat_in;
  logic        finish;
  logic        busy, done;
`ifdef MAT_RESULT_SIGN_EXT_EN
  logic        sign;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  mat_result_reader_if eif();

  mat_result_reader dut (
    .clk    (clk),
    .rst    (rst),
`ifdef MAT_RESULT_SIGN_EXT_EN
    .sign   (sign),
`endif
    .mat_in (mat_in),
    .finish (finish),
    .elem   (eif),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Element k (0-based) of the packed matrix, optionally read as a signed 3-bit value.
  function automatic logic [5:0] model_elem(input logic [95:0] m, input int k, input bit sgn);
    logic [5:0] f;
    int v;
    f = m[95-6*k -: 6];
    if (!sgn) return f;
    v = int'(f[2:0]);
    if (v >= 4) v = v - 8;
    return 6'(v);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(eif.elem_valid), 32'd0);
    chk({tag, "_data"},  32'(eif.elem_data),  32'd0);
    chk({tag, "_idx"},   32'(eif.elem_idx),   32'd0);
    chk({tag, "_last"},  32'(eif.elem_last),  32'd0);
    chk({tag, "_busy"},  32'(busy),           32'd0);
    chk({tag, "_done"},  32'(done),           32'd0);
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random ready
  task automatic stream(input logic [95:0] m, input bit sgn, input int mode, output int cycles);
    int         beat;
    int         cyc;
    bit         r;
    bit         eff_sgn;
    logic [5:0] e;
    beat = 0;
    cyc  = 0;
`ifdef MAT_RESULT_SIGN_EXT_EN
    eff_sgn = sgn;
`else
    eff_sgn = 1'b0;
`endif
    @(negedge clk);
    mat_in = m;
    finish = 1'b1;
`ifdef MAT_RESULT_SIGN_EXT_EN
    sign = sgn;
`endif
    @(posedge clk);
    while (beat < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        mat_in = ~m;
`ifdef MAT_RESULT_SIGN_EXT_EN
        sign = ~sgn;
`endif
      end
      chk("stream_valid", 32'(eif.elem_valid), 32'd1);
      chk("stream_busy",  32'(busy),           32'd1);
      chk("stream_done",  32'(done),           32'd0);
      e = model_elem(m, beat, eff_sgn);
      chk("stream_data",  32'(eif.elem_data),  32'(e));
      chk("stream_idx",   32'(eif.elem_idx),   32'(beat));
      chk("stream_last",  32'(eif.elem_last),  32'(beat == 15));
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc - 1) % 3) == 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      eif.elem_ready = r;
      if (eif.elem_valid && r) beat++;
    end
    chk("stream_beats", 32'(beat), 32'd16);
    cycles = cyc;
    @(negedge clk);
    chk("done_pulse",      32'(done),           32'd1);
    chk("done_valid",      32'(eif.elem_valid), 32'd0);
    chk("done_busy",       32'(busy),           32'd1);
    eif.elem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("after_done",      32'(done),           32'd0);
    chk("after_busy",      32'(busy),           32'd0);
    chk("after_valid",     32'(eif.elem_valid), 32'd0);
  endtask

  task automatic drop_finish();
    @(negedge clk);
    finish = 1'b0;
  endtask

  function automatic logic [95:0] rand_mat();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    int          cyc;
    logic [95:0] m;

    rst            = 1'b1;
    finish         = 1'b0;
    mat_in         = '0;
    eif.elem_ready = 1'b0;
`ifdef MAT_RESULT_SIGN_EXT_EN
    sign           = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Idle with finish low; ready wiggling must not matter
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(eif.elem_valid), 32'd0);
      chk("idle_busy",  32'(busy),           32'd0);
      chk("idle_done",  32'(done),           32'd0);
      eif.elem_ready = 1'($urandom_range(0, 1));
    end

    // Element k = k mod 8
    m = '0;
    for (int k = 1; k <= 16; k++) m[95-6*(k-1) -: 6] = 6'(k % 8);
    stream(m, 1'b0, 0, cyc);
    chk("full_stream_cycles", 32'(cyc), 32'd16);

    // Level-high finish must not retrigger
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      mat_in = rand_mat();
      chk("level_busy",  32'(busy),           32'd0);
      chk("level_valid", 32'(eif.elem_valid), 32'd0);
    end
    drop_finish();
    stream(rand_mat(), 1'b0, 1, cyc);

    drop_finish();
    stream(rand_mat(), 1'b0, 1, cyc);
    for (int t = 0; t < 4; t++) begin
      drop_finish();
      stream(rand_mat(), 1'($urandom_range(0, 1)), 2, cyc);
    end

    // Reset after the 5th accepted beat
    drop_finish();
    @(negedge clk);
    m      = rand_mat();
    mat_in = m;
    finish = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      eif.elem_ready = 1'b1;
    end
    @(negedge clk);
    chk("pre_reset_idx", 32'(eif.elem_idx), 32'd5);
    rst    = 1'b1;
    finish = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_done", 32'(done), 32'd0);
      chk("post_reset_busy", 32'(busy), 32'd0);
    end
    stream(rand_mat(), 1'b0, 0, cyc);
    chk("restart_cycles", 32'(cyc), 32'd16);

`ifdef MAT_RESULT_SIGN_EXT_EN
    m = rand_mat();
    m[95:90] = 6'b000101;
    drop_finish();
    stream(m, 1'b1, 0, cyc);
    drop_finish();
    stream(m, 1'b0, 0, cyc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_result_reader.md
# mat_result_reader

Consumer-side unloader for the 2-bit matrix add/subtract path. It captures the 96-bit packed result matrix (16 elements, 6-bit fields) when the producer raises `finish`. It then streams the elements one per beat over a valid/ready handshake to downstream logic (display, UART, or the next matrix stage). It is the reading end of the adder's result-register interface.

## Interface
Parameters:
- `NUM_ELEM`, 16: elements per matrix.
- `ELEM_W`, 6: field width per element.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mat_in`  in  96  packed result. Element k (1..16) occupies bits [95-6(k-1) -: 6].
- `finish`  in  1  producer done level. It stays high until the producer resets.
- `sign`  in  1  1 = subtraction results. Used only with `MAT_RESULT_SIGN_EXT_EN`.
- `elem_data`  out  6  current element.
- `elem_idx`  out  4  current element index, 0..15.
- `elem_valid`  out  1  beat valid.
- `elem_ready`  in  1  downstream accept.
- `elem_last`  out  1  high with the beat where idx = 15.
- `busy`  out  1  capture held, not idle.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, SEND, DONE.
- Edge detect:
  - `finish_q` registers `finish`.
  - `start` = `finish & ~finish_q`.
  - A level-high `finish` never retriggers.
- IDLE:
  - On `start`: capture `mat_in` into `cap[95:0]`, clear `idx`, go to SEND.
  - Without `start`: stay in IDLE.
- SEND:
  - `elem_valid` = 1.
  - `elem_data` = `cap[95:90]`, post-processed per Configuration.
  - On `elem_valid & elem_ready`:
    - shift `cap` left by 6, zero-filling.
    - `idx` += 1.
    - if `idx` was 15, go to DONE.
  - Without `elem_ready`: data, idx and last hold stable. No beat is dropped or skipped.
- DONE: assert `done` for one cycle, then return to IDLE. Clear `cap`.
- `busy` = (state != IDLE).
- `start` while in SEND or DONE is ignored and not queued. `finish` must fall and rise again for a new capture.
- `finish` falling mid-SEND has no effect. The stream completes.
- `rst` at any point:
  - state = IDLE, `cap` = 0, `idx` = 0, `finish_q` = 0.
  - All outputs are 0 in the next cycle.
  - A partially sent matrix is discarded.
- `elem_ready` high while `elem_valid` is low has no effect.

## Timing
- Reset values: `elem_data` 0, `elem_idx` 0, `elem_valid` 0, `elem_last` 0, `busy` 0, `done` 0.
- Start to first beat:
  - `start` is sampled at edge N.
  - `elem_valid` = 1 during cycle N+1.
- Streaming rate: with `elem_ready` held high, 16 beats occupy cycles N+1..N+16.
- `done` is high in cycle N+17.
- `busy` returns low in cycle N+18.
- Minimum capture-to-capture spacing: 18 cycles plus the `finish` low time.
- Outputs are registered or decoded from registered state only. There is no combinational path from `elem_ready` to `elem_valid`.

## Configuration
- Macro: `MAT_RESULT_SIGN_EXT_EN`.
- Defined:
  - `sign` is registered at capture.
  - With captured sign = 1, `elem_data` = {3{field[2]}, field[2:0]}, i.e. 3-bit two's-complement sign extended to 6 bits.
  - With captured sign = 0, `elem_data` = the raw field.
- Not defined: the `sign` port is absent and `elem_data` = the raw 6-bit field.

## Structure
- Package `mat_result_pkg` holds:
  - `ELEM_W` = 6, `NUM_ELEM` = 16, `MAT_W` = 96.
  - enum `rd_state_t` {IDLE, SEND, DONE}.
  - function `elem_fmt(field, sgn)` for the sign-extension rule.
- Natural sub-module: `result_unload_shifter`. It holds the 96-bit capture register with load, shift and clear inputs, and the top 6-bit tap. The FSM, counter and edge detect stay in the top level.

## Test plan
- Reset then idle: `finish` = 0 for 10 cycles -> `elem_valid`, `busy` and `done` all stay 0.
- Full stream:
  - Stimulus: `mat_in` with element k = k mod 8, `finish` rises, `elem_ready` = 1.
  - Response: 16 beats with data 1,2,...,7,0,1,...,0, `elem_idx` 0..15, `elem_last` only at idx 15, `done` pulse at N+17.
- Backpressure: `elem_ready` toggles 1,0,0,1,... -> no beat lost or duplicated, data stable while stalled, 16 accepts total.
- Level finish:
  - Stimulus: `finish` held high 100 cycles after the stream completes.
  - Response: no second capture. A low-then-high `finish` then captures a new `mat_in`.
- Reset mid-stream:
  - Stimulus: `rst` after the 5th accepted beat.
  - Response: outputs zero next cycle, no `done` pulse, next `finish` edge restarts at idx 0.
- Sign extension, macro defined:
  - Stimulus: `sign` = 1, element 1 field = 6'b000101.
  - Response: `elem_data` = 6'b111101. With `sign` = 0 the same field gives 6'b000101.
